// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared state encoding and arbitration-mode constants for the
//               word-access sequencer of the byte-wide MAR/MDR memory block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_ALO = 4'd1,
        RD_LO  = 4'd2,
        RD_AHI = 4'd3,
        RD_HI  = 4'd4,
        WR_A   = 4'd5,
        WR_D   = 4'd6,
        WR_W   = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-port combinational arbiter, fixed priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       mode,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: round-robin hands the bus to the port not served last.
            2'b11:   gnt = (mode == 1'(ARB_RR) && !last_gnt) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences 16-bit word reads/writes over the byte-wide MAR/MDR
//               memory block and shares it between fetch (0) and execute (1).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int ARB_MODE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    input  logic [DATA_W-1:0]   mem_out,
    output logic [ADDR_W-1:0]   bus_out,
    output logic                bus_oe,
    output logic                mar_load,
    output logic                mdr_load_bus,
    output logic                mdr_load_low,
    output logic                mdr_load_high,
    output logic                ram_write
);

    localparam logic c_arb_mode = (ARB_MODE == ARB_RR);

    state_t              r_state;
    logic                r_last_gnt;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic [1:0]          w_arb_gnt;
    logic                w_sel;
    logic [ADDR_W-1:0]   w_addr_inc;

    rr_arbiter2 u_arb (
        .req      (req),
        .last_gnt (r_last_gnt),
        .mode     (c_arb_mode),
        .gnt      (w_arb_gnt)
    );

    assign gnt        = (r_state == IDLE) ? w_arb_gnt : 2'b00;
    assign w_sel      = gnt[1];
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        r_port     <= w_sel;
                        r_last_gnt <= w_sel;
                        r_we       <= we[w_sel];
                        r_addr     <= w_sel ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
                        r_wdata    <= w_sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                        r_state    <= we[w_sel] ? WR_A : RD_ALO;
                    end
                end
                RD_ALO:  r_state <= RD_LO;
                RD_LO:   r_state <= RD_AHI;
                RD_AHI:  r_state <= RD_HI;
                RD_HI:   r_state <= DONE;
                WR_A:    r_state <= WR_D;
                WR_D:    r_state <= WR_W;
                WR_W:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes and bus are a pure decode of the state register.
    always_comb begin
        bus_out       = '0;
        bus_oe        = 1'b0;
        mar_load      = 1'b0;
        mdr_load_bus  = 1'b0;
        mdr_load_low  = 1'b0;
        mdr_load_high = 1'b0;
        ram_write     = 1'b0;
        done          = 2'b00;
        rdata         = '0;
        case (r_state)
            RD_ALO: begin
                bus_out  = r_addr;
                bus_oe   = 1'b1;
                mar_load = 1'b1;
            end
            RD_LO:  mdr_load_low = 1'b1;
            RD_AHI: begin
                bus_out  = w_addr_inc;
                bus_oe   = 1'b1;
                mar_load = 1'b1;
            end
            RD_HI:  mdr_load_high = 1'b1;
            WR_A: begin
                bus_out  = r_addr;
                bus_oe   = 1'b1;
                mar_load = 1'b1;
            end
            WR_D: begin
                bus_out      = ADDR_W'(r_wdata);
                bus_oe       = 1'b1;
                mdr_load_bus = 1'b1;
            end
            WR_W:   ram_write = 1'b1;
            DONE: begin
                done  = r_port ? 2'b10 : 2'b01;
                rdata = r_we ? '0 : mem_out;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed bench with a byte-wide MAR/MDR memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, req_f;
    logic [31:0] addr, wdata;
    logic [1:0]  gnt, done, gnt_f, done_f;
    logic [15:0] rdata, rdata_f, bus_out, bus_out_f, mdr;
    logic        busy, bus_oe, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write;
    logic        busy_f, bus_oe_f, mar_f, mdrb_f, mdrl_f, mdrh_f, ramw_f;

    logic [7:0]  mem [0:65535];
    logic [15:0] mar, mar_prev;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_out(mdr),
        .bus_out(bus_out), .bus_oe(bus_oe), .mar_load(mar_load),
        .mdr_load_bus(mdr_load_bus), .mdr_load_low(mdr_load_low),
        .mdr_load_high(mdr_load_high), .ram_write(ram_write)
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(0)) dut_fixed (
        .clk(clk), .rst(rst), .req(req_f), .we(2'b00), .addr(addr), .wdata(wdata),
        .gnt(gnt_f), .done(done_f), .rdata(rdata_f), .busy(busy_f), .mem_out(16'h0000),
        .bus_out(bus_out_f), .bus_oe(bus_oe_f), .mar_load(mar_f),
        .mdr_load_bus(mdrb_f), .mdr_load_low(mdrl_f),
        .mdr_load_high(mdrh_f), .ram_write(ramw_f)
    );

    // Memory block model: MAR/MDR registers over a byte array.
    always @(posedge clk) begin
        logic [15:0] hi_a;
        hi_a = mar + 16'd1;
        if (mar_load)      begin mar_prev <= mar; mar <= bus_out; end
        if (mdr_load_bus)  mdr <= bus_out;
        if (mdr_load_low)  mdr[7:0]  <= mem[mar];
        if (mdr_load_high) mdr[15:8] <= mem[mar];
        if (ram_write)     begin mem[mar] <= mdr[7:0]; mem[hi_a] <= mdr[15:8]; end
    end

    wire [4:0] strb = {mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write};

    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(strb) != ((busy && done == 2'b00) ? 1 : 0)) viol++;
            if (bus_oe !== (mar_load | mdr_load_bus)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic access(input int p, input bit w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        int n;
        req[p] = 1'b1;
        we[p]  = w;
        addr[p*16 +: 16]  = a;
        wdata[p*16 +: 16] = d;
        settle();
        n = 0;
        while (gnt == 2'b00 && n < 20) begin cyc(); settle(); n++; end
        rd  = 16'h0;
        lat = 0;
        if (gnt == 2'b00) begin
            check("acc_gnt_timeout", 32'd0, 32'd1);
            req[p] = 1'b0;
            return;
        end
        cyc();
        req[p] = 1'b0;
        settle();
        lat = 1;
        while (done == 2'b00 && lat < 20) begin cyc(); settle(); lat++; end
        rd = rdata;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int          lat, nbad, ng, nf;
        logic [1:0]  g_seq [3];
        logic [1:0]  f_seq [3];
        int          g_t   [3];

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        mem[16'h0000] = 8'hAB;
        mem[16'hFFFF] = 8'hCD;
        mar = 16'h0; mar_prev = 16'h0; mdr = 16'h0;
        rst = 1'b1; req = 2'b00; req_f = 2'b00; we = 2'b00; addr = '0; wdata = '0;

        cyc(); cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        settle();
        check("rst_busy",   busy,    0);
        check("rst_gnt",    gnt,     0);
        check("rst_done",   done,    0);
        check("rst_strobe", strb,    0);
        check("rst_bus",    {bus_oe, bus_out}, 0);
        check("rst_rdata",  rdata,   0);

        // Directed read of 0x0010 on port 0.
        cyc();
        addr[15:0] = 16'h0010; we = 2'b00; req = 2'b01;
        settle(); check("rd_gnt", gnt, 2'b01);
        cyc(); req = 2'b00; settle();
        check("rd_t1_mar", {bus_oe, mar_load}, 2'b11);
        check("rd_t1_bus", bus_out, 16'h0010);
        check("rd_t1_busy", busy, 1);
        cyc(); settle(); check("rd_t2_lo", mdr_load_low, 1);
        cyc(); settle();
        check("rd_t3_mar", {bus_oe, mar_load}, 2'b11);
        check("rd_t3_bus", bus_out, 16'h0011);
        cyc(); settle(); check("rd_t4_hi", mdr_load_high, 1);
        cyc(); settle();
        check("rd_t5_done",  done,  2'b01);
        check("rd_t5_rdata", rdata, 16'h1234);
        cyc(); settle();
        check("rd_t6_idle", {busy, done}, 3'b000);

        // Directed write of 0xBEEF to 0x0020 on port 1.
        addr[31:16] = 16'h0020; wdata[31:16] = 16'hBEEF; we = 2'b10; req = 2'b10;
        settle(); check("wr_gnt", gnt, 2'b10);
        cyc(); req = 2'b00; settle();
        check("wr_t1_mar", {bus_oe, mar_load}, 2'b11);
        check("wr_t1_bus", bus_out, 16'h0020);
        cyc(); settle();
        check("wr_t2_mdr", {bus_oe, mdr_load_bus}, 2'b11);
        check("wr_t2_bus", bus_out, 16'hBEEF);
        cyc(); settle(); check("wr_t3_ram", ram_write, 1);
        cyc(); settle();
        check("wr_t4_done",  done,  2'b10);
        check("wr_t4_rdata", rdata, 16'h0000);
        cyc();
        we = 2'b00;

        access(0, 1'b0, 16'h0020, 16'h0000, rd, lat);
        check("rdback_data", rd,  16'hBEEF);
        check("rdback_lat",  lat, 5);

        access(1, 1'b1, 16'h0040, 16'hA55A, rd, lat);
        check("wr2_lat", lat, 4);
        access(0, 1'b0, 16'h0040, 16'h0000, rd, lat);
        check("wr2_rdback", rd, 16'hA55A);

        // Address wrap at the top of memory.
        access(0, 1'b0, 16'hFFFF, 16'h0000, rd, lat);
        check("wrap_data",   rd,       16'hABCD);
        check("wrap_mar_lo", mar_prev, 16'hFFFF);
        check("wrap_mar_hi", mar,      16'h0000);

        // Port 1 requests while port 0 is being served.
        we = 2'b00; addr = {16'h0020, 16'h0010}; req = 2'b01;
        settle(); check("busy_gnt0", gnt, 2'b01);
        cyc(); req = 2'b10; nbad = 0;
        for (int k = 1; k <= 4; k++) begin
            settle();
            if (gnt != 2'b00) nbad++;
            cyc();
        end
        settle();
        check("busy_no_gnt", nbad, 0);
        check("busy_done0",  done, 2'b01);
        check("busy_gnt_in_done", gnt, 2'b00);
        cyc(); settle(); check("busy_gnt1", gnt, 2'b10);
        cyc(); req = 2'b00;
        repeat (3) cyc();
        cyc(); settle();
        check("busy_done1",  done,  2'b10);
        check("busy_rdata1", rdata, 16'hBEEF);
        cyc();

        // Reset asserted for two cycles while in RD_LO.
        addr[15:0] = 16'h0010; req = 2'b01;
        settle(); check("rstm_gnt", gnt, 2'b01);
        cyc(); req = 2'b00;
        cyc(); rst = 1'b1; settle();
        check("rstm_inflight", mdr_load_low, 1);
        cyc(); settle();
        check("rstm_idle",   busy, 0);
        check("rstm_strobe", {strb, bus_oe}, 0);
        cyc(); rst = 1'b0; settle();
        check("rstm_after", {busy, gnt, done, bus_oe, strb}, 0);

        // Contention held for three accesses in both arbitration modes.
        cyc();
        addr = {16'h0010, 16'h0010}; we = 2'b00; req = 2'b11; req_f = 2'b11;
        ng = 0; nf = 0;
        for (int c = 0; c < 40 && (ng < 3 || nf < 3); c++) begin
            settle();
            if (gnt != 2'b00 && ng < 3)   begin g_seq[ng] = gnt; g_t[ng] = c; ng++; end
            if (gnt_f != 2'b00 && nf < 3) begin f_seq[nf] = gnt_f; nf++; end
            cyc();
        end
        req = 2'b00; req_f = 2'b00;
        check("arb_rr_count", ng, 3);
        check("arb_fx_count", nf, 3);
        if (ng == 3 && nf == 3) begin
            check("arb_rr_0", g_seq[0], 2'b01);
            check("arb_rr_1", g_seq[1], 2'b10);
            check("arb_rr_2", g_seq[2], 2'b01);
            check("arb_fx_0", f_seq[0], 2'b01);
            check("arb_fx_1", f_seq[1], 2'b01);
            check("arb_fx_2", f_seq[2], 2'b01);
            check("arb_spacing", g_t[1] - g_t[0], 6);
        end
        repeat (8) cyc();
        settle();
        check("end_idle",  busy, 0);
        check("strobe_monitor", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
